// File: rtl/parameter_ram.sv
// parameter_ram: 32 x 32-bit flip-flop parameter store with masked write port,
// registered read port and a flat image of the whole array for parallel readers.
// Optional build macro PARAMETER_RAM_WRITE_BYPASS_EN selects write-first reads on a
// same-address read/write collision; the default build is read-first.
module parameter_ram #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [DATA_WIDTH-1:0]                     wdata_in,
  input  logic [ADDR_WIDTH-1:0]                     wadd_in,
  input  logic [DATA_WIDTH-1:0]                     wmask_in,
  input  logic                                      wval_in,
  input  logic                                      wen_in,
  output logic [DATA_WIDTH-1:0]                     rdata_out,
  input  logic [ADDR_WIDTH-1:0]                     radd_in,
  output logic                                      rval_out,
  input  logic                                      ren_in,
  output logic [DATA_WIDTH*(2**ADDR_WIDTH)-1:0]     ram_data_out
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [Depth];
  logic [DATA_WIDTH-1:0] mem_d [Depth];
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rval_q, rval_d;
  logic                  wr_accept;
  logic [DATA_WIDTH-1:0] wr_merged;

  // Write qualification and bit-masked merge with the current word contents.
  always_comb begin
    wr_accept = wen_in & wval_in;
    wr_merged = (mem_q[wadd_in] & ~wmask_in) | (wdata_in & wmask_in);
  end

  // Next-state storage: only the addressed word takes the merged value.
  always_comb begin
    for (int i = 0; i < Depth; i++) begin
      mem_d[i] = mem_q[i];
      if (wr_accept && (wadd_in == ADDR_WIDTH'(i))) begin
        mem_d[i] = wr_merged;
      end
    end
  end

  // Read port next state; rdata holds its value when no read is requested.
  always_comb begin
    rval_d  = ren_in;
    rdata_d = rdata_q;
    if (ren_in) begin
`ifdef PARAMETER_RAM_WRITE_BYPASS_EN
      // Write-first: mem_d already carries any same-cycle merged write.
      rdata_d = mem_d[radd_in];
`else
      // Read-first: return contents as they were before this edge.
      rdata_d = mem_q[radd_in];
`endif
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
      rdata_q <= '0;
      rval_q  <= 1'b0;
    end else begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= mem_d[i];
      end
      rdata_q <= rdata_d;
      rval_q  <= rval_d;
    end
  end

  // Flat image straight from the storage flops, word i at bits [32*i +: 32].
  always_comb begin
    ram_data_out = '0;
    for (int i = 0; i < Depth; i++) begin
      ram_data_out[i*DATA_WIDTH +: DATA_WIDTH] = mem_q[i];
    end
  end

  assign rdata_out = rdata_q;
  assign rval_out  = rval_q;

endmodule

// File: tb/tb_parameter_ram.sv
// Bench for parameter_ram: directed vectors with literal expectations plus a
// word-array reference model compared against every output on each falling edge.
module tb_parameter_ram;

`ifdef PARAMETER_RAM_WRITE_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   wdata_in = '0;
  logic [4:0]    wadd_in = '0;
  logic [31:0]   wmask_in = '0;
  logic          wval_in = 1'b0;
  logic          wen_in = 1'b0;
  logic [31:0]   rdata_out;
  logic [4:0]    radd_in = '0;
  logic          rval_out;
  logic          ren_in = 1'b0;
  logic [1023:0] ram_data_out;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  parameter_ram dut (
    .clk          (clk),
    .rst          (rst),
    .wdata_in     (wdata_in),
    .wadd_in      (wadd_in),
    .wmask_in     (wmask_in),
    .wval_in      (wval_in),
    .wen_in       (wen_in),
    .rdata_out    (rdata_out),
    .radd_in      (radd_in),
    .rval_out     (rval_out),
    .ren_in       (ren_in),
    .ram_data_out (ram_data_out)
  );

  always #5 clk = ~clk;

  // Reference model: plain array of words and the last read result.
  logic [31:0]   m_mem [32];
  logic [31:0]   m_rdata;
  logic          m_rval;
  logic [1023:0] exp_flat;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [31:0] m);
    return (old & ~m) | (d & m);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) m_mem[i] <= '0;
      m_rdata <= '0;
      m_rval  <= 1'b0;
    end else begin
      m_rval <= ren_in;
      if (ren_in) begin
        if (Bypass && wen_in && wval_in && (radd_in == wadd_in))
          m_rdata <= merge(m_mem[wadd_in], wdata_in, wmask_in);
        else
          m_rdata <= m_mem[radd_in];
      end
      if (wen_in && wval_in) m_mem[wadd_in] <= merge(m_mem[wadd_in], wdata_in, wmask_in);
    end
  end

  task automatic check(input string name, input logic [1023:0] act, input logic [1023:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 32; i++) exp_flat[i*32 +: 32] = m_mem[i];
      check("model_rdata", {992'd0, rdata_out}, {992'd0, m_rdata});
      check("model_rval", {1023'd0, rval_out}, {1023'd0, m_rval});
      check("model_flat", ram_data_out, exp_flat);
    end
  end

  // Apply one cycle of inputs; returns 2 time units after the capturing edge.
  task automatic step(input logic we, input logic wv, input logic [4:0] wa,
                      input logic [31:0] wd, input logic [31:0] wm,
                      input logic re, input logic [4:0] ra);
    wen_in = we; wval_in = wv; wadd_in = wa; wdata_in = wd; wmask_in = wm;
    ren_in = re; radd_in = ra;
    @(posedge clk);
    #2;
  endtask

  initial begin
    #1 rst = 1'b0;
    chk_en = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    check("reset_rdata", {992'd0, rdata_out}, 1024'd0);
    check("reset_rval", {1023'd0, rval_out}, 1024'd0);
    check("reset_flat", ram_data_out, 1024'd0);

    step(0, 0, 0, 0, 0, 1, 5'd7);
    check("read7_rdata", {992'd0, rdata_out}, 1024'd0);
    check("read7_rval", {1023'd0, rval_out}, 1024'd1);

    // Full write then read back.
    step(1, 1, 5'd3, 32'hDEADBEEF, 32'hFFFFFFFF, 0, 0);
    check("full_flat", {992'd0, ram_data_out[127:96]}, {992'd0, 32'hDEADBEEF});
    check("idle_rval", {1023'd0, rval_out}, 1024'd0);
    step(0, 0, 0, 0, 0, 1, 5'd3);
    check("full_rdata", {992'd0, rdata_out}, {992'd0, 32'hDEADBEEF});
    check("full_rval", {1023'd0, rval_out}, 1024'd1);

    // Masked writes.
    step(1, 1, 5'd3, 32'h12345678, 32'h0000FFFF, 0, 0);
    check("mask_flat", {992'd0, ram_data_out[127:96]}, {992'd0, 32'hDEAD5678});
    check("hold_rdata", {992'd0, rdata_out}, {992'd0, 32'hDEADBEEF});
    step(1, 1, 5'd3, 32'hFFFFFFFF, 32'h0, 0, 0);
    check("zmask_flat", {992'd0, ram_data_out[127:96]}, {992'd0, 32'hDEAD5678});

    // Write qualifiers.
    step(1, 0, 5'd31, 32'hAAAAAAAA, 32'hFFFFFFFF, 0, 0);
    check("qual_wval0", {992'd0, ram_data_out[1023:992]}, 1024'd0);
    step(0, 1, 5'd31, 32'hAAAAAAAA, 32'hFFFFFFFF, 0, 0);
    check("qual_wen0", {992'd0, ram_data_out[1023:992]}, 1024'd0);

    // Same-address collision.
    step(1, 1, 5'd5, 32'h11111111, 32'hFFFFFFFF, 0, 0);
    step(1, 1, 5'd5, 32'h22222222, 32'hFFFFFFFF, 1, 5'd5);
    check("collide_rdata", {992'd0, rdata_out},
          {992'd0, (Bypass ? 32'h22222222 : 32'h11111111)});
    step(0, 0, 0, 0, 0, 1, 5'd5);
    check("after_collide", {992'd0, rdata_out}, {992'd0, 32'h22222222});

    // Random traffic with an asynchronous reset part-way through.
    for (int i = 0; i < 100; i++) begin
      if (i == 50) begin
        #2 rst = 1'b0;
        #1;
        check("async_rdata", {992'd0, rdata_out}, 1024'd0);
        check("async_rval", {1023'd0, rval_out}, 1024'd0);
        check("async_flat", ram_data_out, 1024'd0);
        step(1, 1, 5'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 5'd1);
        check("in_reset_flat", ram_data_out, 1024'd0);
        #2 rst = 1'b1;
        for (int a = 0; a < 32; a++) begin
          step(0, 0, 0, 0, 0, 1, 5'(a));
          check("post_rst_word", {992'd0, rdata_out}, 1024'd0);
        end
      end
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
           $urandom, $urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)));
    end

    step(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
